// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with occupancy count, threshold flags, sticky errors
// and a selectable show-ahead (FWFT=1) or registered (FWFT=0) read port.
module fifo_flags #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_BITS  = 9,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_BITS-1:0]  w_data,
  input  logic                  clr_err,
  output logic [DATA_BITS-1:0]  r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_N = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_N   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_N   = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  rdat_q, rdat_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, rv_q, rv_d;
  logic                  wa, ra;
  assign full         = cnt_q == FULL_N;
  assign empty        = cnt_q == '0;
  assign almost_full  = cnt_q >= AF_N;
  assign almost_empty = cnt_q <= AE_N;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign r_data       = (FWFT != 0) ? mem_q[rp_q] : rdat_q;
  assign r_valid      = (FWFT != 0) ? ~empty : rv_q;
  // A read frees a slot, so a full FIFO can still take a write in the same cycle.
  always_comb begin
    ra     = rd && !empty;
    wa     = wr && (!full || ra);
    wp_d   = wa ? wp_q + 1'b1 : wp_q;
    rp_d   = ra ? rp_q + 1'b1 : rp_q;
    cnt_d  = (wa && !ra) ? cnt_q + 1'b1 : (ra && !wa) ? cnt_q - 1'b1 : cnt_q;
    ovf_d  = (wr && !wa) || (ovf_q && !clr_err);
    unf_d  = (rd && !ra) || (unf_q && !clr_err);
    rv_d   = ra;
    rdat_d = ra ? mem_q[rp_q] : rdat_q;
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      rv_q   <= 1'b0;
      rdat_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      rv_q   <= rv_d;
      rdat_q <= rdat_d;
    end
  end
  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem_q[wp_q] <= w_data;
  end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: vector table plus scoreboard for the show-ahead instance,
// hand-written sequences for the registered-read instance and mid-burst reset.
module tb_fifo_flags;
  logic       clk = 1'b0, Reset = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [8:0] w_data = '0;
  logic [8:0] r_data;
  logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [5:0] count;
  logic       wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic [8:0] wd1 = '0;
  logic [8:0] r_data1;
  logic       r_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [5:0] count1;

  fifo_flags #(.FWFT(1)) u0 (
    .clk(clk), .Reset(Reset), .wr(wr), .rd(rd), .w_data(w_data), .clr_err(clr_err),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  fifo_flags #(.FWFT(0)) u1 (
    .clk(clk), .Reset(Reset), .wr(wr1), .rd(rd1), .w_data(wd1), .clr_err(clr1),
    .r_data(r_data1), .r_valid(r_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  typedef struct {
    bit         w, r, c;
    logic [8:0] d;
    int         n;
    bit         ov, un;
  } vec_t;

  vec_t       tv[$];
  logic [8:0] sb[$];
  int         errors = 0, checks = 0, pc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, bit r, bit c, logic [8:0] d, int n, bit ov, bit un);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.d = d; v.n = n; v.ov = ov; v.un = un;
    return v;
  endfunction

  // pc is the expected occupancy before this vector; acceptance follows the FIFO rules.
  task automatic apply(input vec_t v, input int k);
    bit ra, wa;
    ra = v.r && pc > 0;
    wa = v.w && (pc < 32 || ra);
    @(negedge clk);
    wr = v.w; rd = v.r; clr_err = v.c; w_data = v.d;
    #1;
    if (ra) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underrun[%0d]: read expected with empty scoreboard", k);
      end else chk($sformatf("r_data[%0d]", k), 32'(r_data), 32'(sb.pop_front()));
    end
    if (wa) sb.push_back(v.d);
    @(posedge clk); #1;
    chk($sformatf("count[%0d]", k), 32'(count), 32'(v.n));
    chk($sformatf("full[%0d]", k), 32'(full), 32'(v.n == 32));
    chk($sformatf("empty[%0d]", k), 32'(empty), 32'(v.n == 0));
    chk($sformatf("almost_full[%0d]", k), 32'(almost_full), 32'(v.n >= 28));
    chk($sformatf("almost_empty[%0d]", k), 32'(almost_empty), 32'(v.n <= 4));
    chk($sformatf("overflow[%0d]", k), 32'(overflow), 32'(v.ov));
    chk($sformatf("underflow[%0d]", k), 32'(underflow), 32'(v.un));
    pc = v.n;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
    chk({tag, "_rvalid"}, 32'(r_valid), 0);
    chk({tag, "_rvalid1"}, 32'(r_valid1), 0);
    chk({tag, "_rdata1"}, 32'(r_data1), 0);
    chk({tag, "_count1"}, 32'(count1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 1; i <= 32; i++) tv.push_back(mk(1, 0, 0, 9'(i), i, 0, 0));
    tv.push_back(mk(1, 0, 0, 9'h0ff, 32, 1, 0));
    tv.push_back(mk(0, 0, 1, 9'h000, 32, 0, 0));
    tv.push_back(mk(1, 1, 0, 9'h155, 32, 0, 0));
    for (int i = 31; i >= 0; i--) tv.push_back(mk(0, 1, 0, 9'h000, i, 0, 0));
    tv.push_back(mk(0, 1, 0, 9'h000, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 9'h000, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 9'h0aa, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 9'h000, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 9'h000, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 9'h000, 0, 0, 0));
    for (int i = 1; i <= 10; i++) tv.push_back(mk(1, 0, 0, 9'(9'h100 + i), i, 0, 0));
    for (int i = 0; i < 30; i++) tv.push_back(mk(1, 1, 0, 9'(9'h180 + i), 10, 0, 0));

    #2;
    chk_reset("init");
    @(negedge clk);
    Reset = 1'b1;

    @(negedge clk); wr1 = 1'b1; wd1 = 9'h123;
    @(posedge clk); #1;
    chk("fwft0_rvalid_idle", 32'(r_valid1), 0);
    chk("fwft0_count_w", 32'(count1), 1);
    @(negedge clk); wr1 = 1'b0; rd1 = 1'b1;
    @(posedge clk); #1;
    chk("fwft0_rvalid", 32'(r_valid1), 1);
    chk("fwft0_rdata", 32'(r_data1), 32'h123);
    chk("fwft0_count_r", 32'(count1), 0);
    @(negedge clk); rd1 = 1'b0;
    @(posedge clk); #1;
    chk("fwft0_rvalid_after", 32'(r_valid1), 0);
    chk("fwft0_rdata_hold", 32'(r_data1), 32'h123);

    for (int k = 0; k < tv.size(); k++) apply(tv[k], k);

    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    #2 Reset = 1'b0;
    #1 chk_reset("midreset");
    sb.delete();
    pc = 0;
    @(negedge clk);
    Reset = 1'b1;
    apply(mk(1, 0, 0, 9'h077, 1, 0, 0), 900);
    apply(mk(0, 1, 0, 9'h000, 0, 0, 0), 901);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
